// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: default frame geometry and the RX/TX state
// encodings used by the echo responder (and the existing UART).
// State literals carry RX_/TX_ prefixes because both enums live in the
// same package scope and would otherwise collide.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int WORD_SIZE   = 8;   // data bits per frame
    localparam int PULSE_WIDTH = 4;   // clk cycles per bit, even and >= 4
    localparam int PACKET_SIZE = 10;  // start + data + stop

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Small first-word-fall-through circular buffer. rd_data always shows the
// oldest entry, so a consumer can pop and use the word in the same cycle.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   push, wr_data      write request; ignored when full unless popping too
//   pop, rd_data       read request (never issued while empty), head word
//   full, empty, count occupancy flags and entry count
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WORD_SIZE  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            push,
    input  logic [WORD_SIZE-1:0]            wr_data,
    input  logic                            pop,
    output logic [WORD_SIZE-1:0]            rd_data,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [CW-1:0]        count_reg;
    logic                 wr_en;
    logic                 rd_en;

    assign full    = (count_reg == CW'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rd_data = mem[rd_ptr_reg];

    // A pop frees the head slot in the same cycle, so push-while-full is
    // accepted when paired with a pop.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers are exactly log2(depth) wide, so wrap-around is free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_responder.sv
// ---------------------------------------------------------------------------
// uart_echo_responder
// Loopback end of the UART link: deserializes frames from rx (mid-bit
// sampling), buffers good words in a FIFO and reserializes them on tx.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   rx          serial input (idle high, asynchronous to clk)
//   echo_en     1 = drain the FIFO onto tx, 0 = hold words
//   tx          serial output (idle high, registered)
//   rx_word     last correctly framed word; rx_valid pulses on update
//   frame_err   one-cycle pulse when a stop bit is sampled low
//   overflow    sticky: a received word was dropped on a full FIFO
//   fifo_count  FIFO occupancy
// ---------------------------------------------------------------------------
module uart_echo_responder
    import uart_pkg::*;
#(
    parameter int WORD_SIZE   = uart_pkg::WORD_SIZE,
    parameter int PULSE_WIDTH = uart_pkg::PULSE_WIDTH,
    parameter int PACKET_SIZE = uart_pkg::PACKET_SIZE,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            rx,
    input  logic                            echo_en,
    output logic                            tx,
    output logic [WORD_SIZE-1:0]            rx_word,
    output logic                            rx_valid,
    output logic                            frame_err,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int CW = $clog2(PULSE_WIDTH);
    localparam int BW = $clog2(WORD_SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(PULSE_WIDTH/2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_SIZE - 1);

    // ---------------- input synchronizer ----------------
    logic rx_meta_reg;
    logic rx_s_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t            rx_state_reg, rx_state_next;
    logic [CW-1:0]        rx_cnt_reg, rx_cnt_next;
    logic [BW-1:0]        rx_bit_reg, rx_bit_next;
    logic [WORD_SIZE-1:0] rx_shift_reg, rx_shift_next;
    logic [WORD_SIZE-1:0] rx_word_reg, rx_word_next;
    logic                 rx_valid_reg, rx_valid_next;
    logic                 frame_err_reg, frame_err_next;

    always_comb begin
        rx_state_next  = rx_state_reg;
        rx_cnt_next    = rx_cnt_reg;
        rx_bit_next    = rx_bit_reg;
        rx_shift_next  = rx_shift_reg;
        rx_word_next   = rx_word_reg;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (!rx_s_reg) begin
                    rx_state_next = RX_START;
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                end
            end
            RX_START: begin
                // Half a bit in: a line that is high again was a glitch.
                if (rx_cnt_reg == CNT_HALF) begin
                    rx_cnt_next   = '0;
                    rx_state_next = rx_s_reg ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == CNT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_s_reg, rx_shift_reg[WORD_SIZE-1:1]};
                    if (rx_bit_reg == BIT_LAST) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + BW'(1);
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == CNT_LAST) begin
                    rx_cnt_next = '0;
                    if (rx_s_reg) begin
                        rx_valid_next = 1'b1;
                        rx_word_next  = rx_shift_reg;
                        rx_state_next = RX_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        rx_state_next  = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + CW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                // A stuck-low line must not be parsed as a fresh start bit.
                if (rx_s_reg) rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state_reg  <= RX_IDLE;
            rx_cnt_reg    <= '0;
            rx_bit_reg    <= '0;
            rx_shift_reg  <= '0;
            rx_word_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_state_reg  <= rx_state_next;
            rx_cnt_reg    <= rx_cnt_next;
            rx_bit_reg    <= rx_bit_next;
            rx_shift_reg  <= rx_shift_next;
            rx_word_reg   <= rx_word_next;
            rx_valid_reg  <= rx_valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // ---------------- echo FIFO ----------------
    logic [WORD_SIZE-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 tx_pop;
    logic                 overflow_reg;

    // The valid pulse doubles as the push strobe, so the word lands in the
    // FIFO one cycle after rx_word updates.
    uart_sync_fifo #(
        .WORD_SIZE  (WORD_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (rx_valid_reg),
        .wr_data (rx_word_reg),
        .pop     (tx_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_reg <= 1'b0;
        end else if (rx_valid_reg && fifo_full && !tx_pop) begin
            overflow_reg <= 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    // The whole frame (start, data, stop) is loaded into one shifter that
    // fills with ones, so tx is always frame[0] and idles high naturally.
    tx_state_t              tx_state_reg, tx_state_next;
    logic [CW-1:0]          tx_cnt_reg, tx_cnt_next;
    logic [BW-1:0]          tx_bit_reg, tx_bit_next;
    logic [PACKET_SIZE-1:0] tx_frame_reg, tx_frame_next;
    logic                   tx_reg;

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_frame_next = tx_frame_reg;
        tx_pop        = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (echo_en && !fifo_empty) begin
                    tx_pop        = 1'b1;
                    tx_frame_next = {1'b1, fifo_rd_data, 1'b0};
                    tx_cnt_next   = '0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_frame_next = {1'b1, tx_frame_reg[PACKET_SIZE-1:1]};
                    tx_state_next = TX_DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_frame_next = {1'b1, tx_frame_reg[PACKET_SIZE-1:1]};
                    if (tx_bit_reg == BIT_LAST) begin
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_bit_next = tx_bit_reg + BW'(1);
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = TX_IDLE;
                end else begin
                    tx_cnt_next = tx_cnt_reg + CW'(1);
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_frame_reg <= '1;
            tx_reg       <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_frame_reg <= tx_frame_next;
            tx_reg       <= tx_frame_next[0];
        end
    end

    assign tx        = tx_reg;
    assign rx_word   = rx_word_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_uart_echo_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_echo_responder
// Scoreboard bench: the stimulus side drives serial frames on rx and pushes
// the words it expects into queues; independent monitors pop and compare on
// rx_valid and on every frame decoded from tx.
// ---------------------------------------------------------------------------
module tb_uart_echo_responder;

    localparam int PW    = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic       echo_en = 1'b1;
    logic       tx;
    logic [7:0] rx_word;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    uart_echo_responder #(
        .WORD_SIZE   (8),
        .PULSE_WIDTH (PW),
        .PACKET_SIZE (10),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .echo_en    (echo_en),
        .tx         (tx),
        .rx_word    (rx_word),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a bounded queue standing in for the echo buffer when
    // echo is held off, plus the expected-word queues for both monitors.
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] hold_q[$];
    bit         echo_model = 1'b1;
    bit         exp_ovf    = 1'b0;
    logic [7:0] last_good  = 8'h00;

    int  frame_err_cnt = 0;
    int  last_rxv_cyc  = 0;
    bit  check_lat     = 1'b0;
    bit  track_max     = 1'b0;
    int  max_cnt       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_push(input logic [7:0] w);
        exp_rx.push_back(w);
        last_good = w;
        if (echo_model) exp_tx.push_back(w);
        else if (hold_q.size() < DEPTH) hold_q.push_back(w);
        else exp_ovf = 1'b1;
    endtask

    task automatic set_echo(input bit v);
        echo_en    = v;
        echo_model = v;
        if (v) while (hold_q.size() != 0) exp_tx.push_back(hold_q.pop_front());
    endtask

    // Drive one frame; called and returns on a falling clock edge.
    task automatic send_word(input logic [7:0] w, input bit good = 1'b1, input int stop_len = PW);
        logic [9:0] f;
        f = {1'b1, w, 1'b0};
        if (good) model_push(w);
        for (int k = 0; k < 9; k++) begin
            rx = f[k];
            repeat (PW) @(negedge clk);
        end
        rx = good;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    // ---------------- RX monitor ----------------
    logic [7:0] rx_e;
    always @(negedge clk) begin
        if (rstn) begin
            if (track_max && int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (frame_err) frame_err_cnt++;
            if (rx_valid) begin
                last_rxv_cyc = cyc;
                if (exp_rx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=%0h required=none", rx_word);
                end else begin
                    rx_e = exp_rx.pop_front();
                    check("rx_word", rx_word, rx_e);
                end
            end
        end
    end

    // ---------------- TX monitor ----------------
    bit         tx_busy = 1'b0;
    int         tx_t    = 0;
    int         bit_k   = 0;
    logic [9:0] tx_bits = '0;
    logic [7:0] tx_e;
    always @(negedge clk) begin
        if (!rstn) begin
            tx_busy = 1'b0;
        end else if (!tx_busy) begin
            if (tx === 1'b0) begin
                tx_busy = 1'b1;
                tx_t    = 0;
                tx_bits = '0;
                if (check_lat) begin
                    check("tx_latency", cyc - last_rxv_cyc, 2);
                    check_lat = 1'b0;
                end
            end
        end else begin
            tx_t++;
            if ((tx_t % PW) == PW/2) begin
                bit_k = tx_t / PW;
                tx_bits[bit_k] = tx;
                if (bit_k == 9) begin
                    tx_busy = 1'b0;
                    check("tx_start_bit", tx_bits[0], 1'b0);
                    check("tx_stop_bit", tx_bits[9], 1'b1);
                    if (exp_tx.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_unexpected actual=%0h required=none", tx_bits[8:1]);
                    end else begin
                        tx_e = exp_tx.pop_front();
                        check("tx_word", tx_bits[8:1], tx_e);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_rx.size() != 0 || tx_busy || fifo_count != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < 3000, 1'b1);
        // Extra quiet time so a stray transmission would still be caught.
        repeat (60) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] stream [10] = '{8'h55, 8'hA3, 8'h7E, 8'h00, 8'hFF, 8'hC3, 8'h3C, 8'h5A, 8'h81, 8'h1E};
    int fe0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_rx_word", rx_word, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_fifo_count", fifo_count, 3'd0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Single word with latency check
        check_lat = 1'b1;
        send_word(8'hA1);
        wait_idle();
        check("latency_checked", check_lat, 1'b0);

        // Back-to-back stream
        track_max = 1'b1;
        max_cnt   = 0;
        for (int i = 0; i < 10; i++) send_word(stream[i]);
        wait_idle();
        track_max = 1'b0;
        check("stream_max_count_le2", max_cnt <= 2, 1'b1);
        check("stream_overflow", overflow, 1'b0);
        check("stream_frame_err", frame_err_cnt, 0);

        // Random words with random idle gaps
        for (int i = 0; i < 16; i++) begin
            send_word(8'($urandom));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_idle();

        // Framing error: stop bit held low for 8 clk
        fe0 = frame_err_cnt;
        send_word(8'h3C, 1'b0, 8);
        repeat (10) @(negedge clk);
        check("framing_err_pulse", frame_err_cnt, fe0 + 1);
        check("framing_fifo_count", fifo_count, 3'd0);
        check("framing_rx_word_kept", rx_word, last_good);
        send_word(8'h5A);
        wait_idle();

        // One-clock glitch on rx
        fe0 = frame_err_cnt;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_frame_err", frame_err_cnt, fe0);
        check("glitch_rx_word_kept", rx_word, last_good);
        send_word(8'h96);
        wait_idle();

        // Overflow with echo held off
        set_echo(1'b0);
        for (int i = 1; i <= 5; i++) begin
            send_word(8'(i * 8'h11));
            repeat (6) @(negedge clk);
            if (i == 4) begin
                check("ovf_count_at4", fifo_count, 3'd4);
                check("ovf_flag_at4", overflow, exp_ovf);
            end
        end
        check("ovf_count_at5", fifo_count, 3'd4);
        check("ovf_flag_at5", overflow, exp_ovf);
        set_echo(1'b1);
        wait_idle();
        check("ovf_sticky", overflow, 1'b1);

        // Reset in the middle of RX and TX data bits
        send_word(8'h6B);
        begin
            logic [9:0] f;
            f = {1'b1, 8'hC5, 1'b0};
            for (int k = 0; k < 5; k++) begin
                rx = f[k];
                repeat (PW) @(negedge clk);
            end
        end
        check("midframe_tx_busy", tx_busy, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("midreset_tx", tx, 1'b1);
        check("midreset_fifo_count", fifo_count, 3'd0);
        check("midreset_overflow", overflow, 1'b0);
        check("midreset_rx_valid", rx_valid, 1'b0);
        exp_tx.delete();
        exp_rx.delete();
        hold_q.delete();
        exp_ovf = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        send_word(8'h81);
        wait_idle();
        check("final_rx_word", rx_word, 8'h81);

        check("exp_rx_empty", exp_rx.size(), 0);
        check("exp_tx_empty", exp_tx.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_echo_responder.md
Name: uart_echo_responder

Overview:
- Far end of the UART link: receives framed words on `rx`, buffers them in a small FIFO, and retransmits them unchanged on `tx`.
- Used as the loopback responder for the board-level link test. Host traffic is echoed back and checked by the initiator.
- Contains its own deserializer (mid-bit sampling), a FIFO, and a serializer, all on one clock.

Parameters:
- WORD_SIZE, 8, data bits per frame.
- PULSE_WIDTH, 4, clk cycles per bit (CLOCK_FREQ/BAUD); must be >= 4 and even.
- PACKET_SIZE, 10, bits per frame: start + WORD_SIZE data + stop.
- FIFO_DEPTH, 4, echo buffer entries; must be a power of 2.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- rx  in  1  serial input, idle high, asynchronous to clk.
- echo_en  in  1  1 = retransmit buffered words; 0 = hold words in the FIFO.
- tx  out  1  serial output, idle high.
- rx_word  out  WORD_SIZE  last correctly framed received word.
- rx_valid  out  1  one-cycle pulse when rx_word updates.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rstn low, asynchronous): both FSMs go to IDLE, FIFO is emptied, tx=1, rx_word=0, and rx_valid, frame_err, overflow and fifo_count are all 0. Reset mid-frame abandons the frame; there is no partial push and no partial transmit.
- rx passes through a 2-flop synchronizer (rx_s); all RX decisions use rx_s.
- RX FSM:
  - IDLE: when rx_s=0, go to START and clear the bit counter.
  - START: wait PULSE_WIDTH/2 cycles, then sample. If rx_s=0, go to DATA. If rx_s=1, treat as a glitch and return to IDLE with no flags.
  - DATA: sample every PULSE_WIDTH cycles, LSB first, WORD_SIZE samples, then go to STOP.
  - STOP: sample after PULSE_WIDTH cycles.
    - rx_s=1: next cycle rx_valid=1, rx_word=shift register, FIFO push; go to IDLE.
    - rx_s=0: next cycle frame_err=1, no push, rx_word unchanged; go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a stuck-low line from being re-parsed as a new frame.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits; wrap-around is natural.
  - Push while full (and no pop in the same cycle) drops the incoming word and sets overflow; overflow clears only on reset.
  - Simultaneous push and pop is legal at any occupancy, including full; fifo_count is unchanged.
  - Pop while empty cannot occur.
- TX FSM:
  - IDLE: if echo_en=1 and the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx=0 for PULSE_WIDTH cycles.
  - DATA: WORD_SIZE bits, LSB first, PULSE_WIDTH cycles each.
  - STOP: tx=1 for PULSE_WIDTH cycles, then go to IDLE.
  - tx is registered: it changes on the cycle after the state/bit-counter change and never glitches.
- Latency: the FIFO entry is visible the cycle after the push, so an idle TX pops one cycle later. tx falls exactly 2 clk after the rising edge of rx_valid.
- Back-to-back TX: after STOP completes, IDLE pops the next word in the same cycle, giving exactly one idle-high cycle in addition to the stop bit. RX and TX run fully independently.
- echo_en dropping mid-frame: the current frame completes; no new pop occurs.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH}
  - tx_state_t {IDLE, START, DATA, STOP}
  - default constants WORD_SIZE, PULSE_WIDTH, PACKET_SIZE, shared with the existing UART.
- One sub-module, uart_sync_fifo (parameters WORD_SIZE and FIFO_DEPTH; push/pop/full/empty/count). It is reusable by the existing UART. RX and TX FSMs stay in the top module.

Test Plan:
- Single word: drive 0xA1 on rx (PULSE_WIDTH=4) with echo_en=1 -> rx_valid pulse with rx_word=0xA1. tx falls 2 clk later and emits 0,1,0,0,0,0,1,0,1,1 at 4 clk/bit.
- Stream: drive 0x55, A3, 7E, 00, FF, C3, 3C, 5A, 81, 1E back-to-back -> all ten echoed in order. overflow=0, frame_err never asserted, fifo_count<=2.
- Overflow: with echo_en=0, send 0x11..0x55 (5 words) -> fifo_count=4 and overflow=1 after the 5th. Then set echo_en=1 -> 0x11, 22, 33, 44 are transmitted and 0x55 is never transmitted.
- Framing: send 0x3C with the stop bit held low for 8 clk -> one frame_err pulse, no rx_valid, fifo_count=0, tx stays 1. A following correctly framed 0x5A is then echoed.
- Glitch: hold rx low for 1 clk -> no rx_valid, no frame_err, and the RX FSM returns to IDLE.
- Reset: assert rstn low mid-DATA on both RX and TX -> tx=1 immediately and fifo_count=0. After release, 0x81 is received and echoed correctly.
